// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle MIPS datapath.
// MULT uses radix-2 Booth recoding. DIV uses restoring division on operand
// magnitudes, followed by a sign fix-up step. Each operation takes WIDTH
// iterations, one per clock. Results land in hi/lo, with a one-cycle done pulse.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multOP,
    input  logic             divOP,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Iteration counter; shared by both algorithms.
    logic [CNT_W-1:0] r_cnt;
    logic             w_last_iter;

    // Start decode: multiply has priority over divide.
    logic w_mult_start;
    logic w_div_start;
    logic w_b_zero;
    logic w_dz_start;

    // Booth accumulator: {upper partial product, multiplier, booth bit}.
    // The upper field is one bit wider than the operands. This keeps the
    // subtraction of a most-negative multiplicand from overflowing before the
    // arithmetic shift.
    logic [2*WIDTH+1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     w_upper;
    logic [WIDTH:0]     w_mcand_ext;
    logic [WIDTH:0]     w_upper_sum;
    logic [2*WIDTH+1:0] w_acc_next;

    // Restoring divider state.
    // The dividend magnitude shifts out of r_quo while quotient bits shift in.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic             r_is_div;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    assign w_mult_start = multOP;
    assign w_div_start  = divOP & ~multOP;
    assign w_b_zero     = (b == '0);
    assign w_dz_start   = (r_state == IDLE) & w_div_start & w_b_zero;
    assign w_last_iter  = (r_cnt == CNT_W'(WIDTH - 1));

    // Magnitudes. The most negative value maps to 2^(WIDTH-1),
    // which is still exact as an unsigned WIDTH-bit number.
    assign w_a_mag = a[WIDTH-1] ? -a : a;
    assign w_b_mag = b[WIDTH-1] ? -b : b;

    // One Booth step: add/subtract the multiplicand based on the bit pair, then arithmetic shift right.
    always_comb begin
        w_upper     = r_acc[2*WIDTH+1:WIDTH+1];
        w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};
        w_upper_sum = w_upper;
        case (r_acc[1:0])
            2'b01:   w_upper_sum = w_upper + w_mcand_ext;
            2'b10:   w_upper_sum = w_upper - w_mcand_ext;
            default: w_upper_sum = w_upper;
        endcase
        w_acc_next = {w_upper_sum[WIDTH], w_upper_sum, r_acc[WIDTH:1]};
    end

    // One restoring-division step. The trial difference is only kept when it
    // fits. In that case it is below the divisor, so its low WIDTH bits are exact.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_fits      = (w_rem_shift >= {1'b0, r_divisor});
        w_diff      = w_rem_shift[WIDTH-1:0] - r_divisor;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        divZero      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mult_start) begin
                    w_state_next = MULT;
                end else if (w_div_start) begin
                    w_state_next = w_b_zero ? DONE : DIV;
                end
            end
            MULT: begin
                busy = 1'b1;
                if (w_last_iter) begin
                    w_state_next = FIX;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (w_last_iter) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                busy         = 1'b1;
                w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                divZero      = r_dz;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on start, advanced on every algorithm step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (r_state == MULT || r_state == DIV) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Operand capture and per-cycle algorithm steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_div  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mult_start) begin
                        r_acc    <= {{(WIDTH+1){1'b0}}, b, 1'b0};
                        r_mcand  <= a;
                        r_is_div <= 1'b0;
                    end else if (w_div_start && !w_b_zero) begin
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r   <= a[WIDTH-1];
                        r_is_div  <= 1'b1;
                    end
                end
                MULT: begin
                    r_acc <= w_acc_next;
                end
                DIV: begin
                    r_rem <= w_fits ? w_diff : w_rem_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                end
                default: begin
                end
            endcase
        end
    end

    // Divide-by-zero flag. It is captured on the start cycle and shown only in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dz <= 1'b0;
        end else begin
            r_dz <= w_dz_start;
        end
    end

    // Result registers: loaded once in FIX, with the division sign fix-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIX) begin
            if (r_is_div) begin
                r_lo <= r_neg_q ? -r_quo : r_quo;
                r_hi <= r_neg_r ? -r_rem : r_rem;
            end else begin
                r_hi <= r_acc[2*WIDTH:WIDTH+1];
                r_lo <= r_acc[WIDTH:1];
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit. Expected hi/lo/divZero/latency are
// computed with 64-bit signed arithmetic when an operation is started. They
// are queued, then popped and compared when the done pulse appears.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         multOP;
    logic         divOP;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         divZero;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .multOP  (multOP),
        .divOP   (divOP),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .divZero (divZero)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Model of the last completed hi/lo, needed for divide-by-zero.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_expect(input bit is_mult, input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t   e;
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(ea));
        sb = longint'($signed(eb));
        if (is_mult) begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.lat = 34;
        end else if (eb == '0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
            e.lat = 1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
            e.dz = 1'b0;
            e.lat = 34;
        end
        m_hi = e.hi;
        m_lo = e.lo;
        sb_q.push_back(e);
    endtask

    // Drive a one-cycle start pulse (cycle T), then scramble the operands.
    // Returns 1ns after the edge that ends cycle T, i.e. inside cycle T+1.
    task automatic start_op(input logic m, input logic d, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(posedge clk);
        #1;
        multOP = m;
        divOP  = d;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        multOP = 1'b0;
        divOP  = 1'b0;
        a      = $urandom;
        b      = $urandom;
    endtask

    // Wait (bounded) for done, optionally pulse divOP at cycle T+inject_at,
    // then check the popped expectation, busy behaviour and pulse width.
    task automatic run_to_done(input string tag, input int inject_at);
        int   k;
        int   busy_low;
        exp_t e;
        k        = 1;
        busy_low = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy !== 1'b1) busy_low++;
            if (k == inject_at) begin
                divOP = 1'b1;
                a     = 32'd9;
                b     = 32'd3;
            end
            @(posedge clk);
            #1;
            divOP = 1'b0;
            k++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'd1);
        chk({tag, " sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, " latency"}, 64'(k), 64'(e.lat));
            chk({tag, " hi"}, 64'(hi), 64'(e.hi));
            chk({tag, " lo"}, 64'(lo), 64'(e.lo));
            chk({tag, " divZero"}, 64'(divZero), 64'(e.dz));
        end
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " busy_low_cycles"}, 64'(busy_low), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " divZero_clear"}, 64'(divZero), 64'd0);
    endtask

    initial begin : stim
        int done_seen;
        reset  = 1'b1;
        multOP = 1'b0;
        divOP  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset divZero", 64'(divZero), 64'd0);
        reset = 1'b0;

        // Signed multiplies, including the most-negative corner.
        push_expect(1'b1, 32'd7, 32'hFFFF_FFFD);
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        run_to_done("mul 7*-3", 0);

        push_expect(1'b1, 32'h8000_0000, 32'h8000_0000);
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        run_to_done("mul minneg^2", 0);

        push_expect(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
        start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
        run_to_done("mul max*minneg", 0);

        // Signed divides over the sign combinations plus the overflow corner.
        push_expect(1'b0, 32'hFFFF_FFF9, 32'd2);
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_to_done("div -7/2", 0);

        push_expect(1'b0, 32'd7, 32'hFFFF_FFFE);
        start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_to_done("div 7/-2", 0);

        push_expect(1'b0, 32'd100, 32'd7);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        run_to_done("div 100/7", 0);

        push_expect(1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_to_done("div -100/-7", 0);

        push_expect(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_done("div minneg/-1", 0);

        // Preload hi=0x11, lo=0x22, then divide by zero must leave them intact.
        push_expect(1'b0, 32'h0000_0451, 32'h0000_0020);
        start_op(1'b0, 1'b1, 32'h0000_0451, 32'h0000_0020);
        run_to_done("div preload", 0);

        push_expect(1'b0, 32'd5, 32'd0);
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        run_to_done("div by zero", 0);

        // A divOP arriving mid-multiply must be ignored.
        push_expect(1'b1, 32'h0001_2345, 32'hFFFF_F889);
        start_op(1'b1, 1'b0, 32'h0001_2345, 32'hFFFF_F889);
        run_to_done("mul busy-ignore", 10);

        // Both starts together: multiply wins.
        push_expect(1'b1, 32'hFFFF_FFFB, 32'd6);
        start_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd6);
        run_to_done("mul+div both", 0);

        // Reset at T+15 of a divide aborts it without a done pulse.
        start_op(1'b0, 1'b1, 32'd1000, 32'd7);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        chk("abort no_done", 64'(done_seen), 64'd0);

        push_expect(1'b1, 32'd3, 32'd4);
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        run_to_done("mul 3*4 after reset", 0);

        chk("sb drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
